// File: rtl/vad_pkg.sv
// Shared constants, FSM state encoding and result encoding for the VAD frame scheduler.
package vad_pkg;

    localparam int FRAME_LEN = 20;
    localparam int WINDOW    = 6;
    localparam int SLOT_W    = 3;
    localparam int IDX_W     = 5;
    localparam int HELD_W    = 3;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [HELD_W-1:0] HELD_FULL = HELD_W'(WINDOW);

    localparam logic [1:0] RESULT_NONE = 2'b00;

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = 2'd0,
        ST_STREAM     = 2'd1,
        ST_WAIT_CORE  = 2'd2
    } vad_state_e;

endpackage

// File: rtl/vad_ring_ptr.sv
// Mod-WINDOW slot pointer: optional load, otherwise increments with wrap by compare.
module vad_ring_ptr
    import vad_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [SLOT_W-1:0] load_val_i,
    output logic [SLOT_W-1:0] ptr_o,
    output logic [SLOT_W-1:0] next_o
);

    logic [SLOT_W-1:0] ptr_q;

    assign next_o = (ptr_q == SLOT_LAST) ? '0 : ptr_q + SLOT_W'(1);
    assign ptr_o  = ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (load_i) begin
            ptr_q <= load_val_i;
        end else if (inc_i) begin
            ptr_q <= next_o;
        end
    end

endmodule

// File: rtl/vad_frame_scheduler.sv
// Frame intake handshake, WINDOW-deep slot ring and oldest-first window streaming
// into the BNN core; captures the core decision.
module vad_frame_scheduler
    import vad_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_en,
    output logic              empty,
    output logic              wr_en,
    output logic [SLOT_W-1:0] wr_slot,
    output logic              rd_en,
    output logic [SLOT_W-1:0] rd_slot,
    output logic [IDX_W-1:0]  rd_idx,
    output logic              core_start,
    input  logic              core_done,
    input  logic [1:0]        core_result,
    output logic [1:0]        result,
    output logic              result_valid,
    output logic [2:0]        frames_held,
    output logic [1:0]        dbg_state_o
);

    vad_state_e        state_q, state_d;
    logic [HELD_W-1:0] held_q, held_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        result_q;
    logic              result_valid_q;
    logic              core_start_q;
    logic              accept;
    logic              rd_inc, rd_load;
    logic [SLOT_W-1:0] wr_ptr, wr_ptr_next;
    logic [SLOT_W-1:0] rd_ptr, rd_ptr_next;

    // Handshake: a frame is taken exactly when read_en meets empty; read_en otherwise has no effect.
    assign accept = read_en && (state_q == ST_WAIT_FRAME);
    assign held_d = (accept && held_q != HELD_FULL) ? held_q + HELD_W'(1) : held_q;

    vad_ring_ptr u_wr_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (accept),
        .load_i     (1'b0),
        .load_val_i ('0),
        .ptr_o      (wr_ptr),
        .next_o     (wr_ptr_next)
    );

    // Stream starts at the slot the write pointer moves to, which is the oldest frame.
    vad_ring_ptr u_rd_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (rd_inc),
        .load_i     (rd_load),
        .load_val_i (wr_ptr_next),
        .ptr_o      (rd_ptr),
        .next_o     (rd_ptr_next)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rd_inc  = 1'b0;
        rd_load = 1'b0;
        case (state_q)
            ST_WAIT_FRAME: begin
                if (accept && held_d == HELD_FULL) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                    rd_load = 1'b1;
                end
            end
            ST_STREAM: begin
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    // The newest slot sits just behind the write pointer.
                    if (rd_ptr_next == wr_ptr) begin
                        state_d = ST_WAIT_CORE;
                    end else begin
                        rd_inc = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_WAIT_CORE: begin
                if (core_done) begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            default: state_d = ST_WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_WAIT_FRAME;
            held_q         <= '0;
            idx_q          <= '0;
            result_q       <= RESULT_NONE;
            result_valid_q <= 1'b0;
            core_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            held_q         <= held_d;
            idx_q          <= idx_d;
            core_start_q   <= rd_load;
            result_valid_q <= (state_q == ST_WAIT_CORE) && core_done;
            if ((state_q == ST_WAIT_CORE) && core_done) begin
                result_q <= core_result;
            end
        end
    end

    assign empty        = (state_q == ST_WAIT_FRAME);
    assign wr_en        = accept;
    assign wr_slot      = wr_ptr;
    assign rd_en        = (state_q == ST_STREAM);
    assign rd_slot      = rd_ptr;
    assign rd_idx       = idx_q;
    assign core_start   = core_start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign frames_held  = held_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_vad_frame_scheduler.sv
// Self-checking bench for vad_frame_scheduler: directed table, corner sequences and
// randomized traffic against a frame-counting reference model.
module tb_vad_frame_scheduler;
    import vad_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       read_en = 1'b0;
    logic       core_done = 1'b0;
    logic [1:0] core_result = 2'b00;
    logic       empty, wr_en, rd_en, core_start, result_valid;
    logic [2:0] wr_slot, rd_slot, frames_held;
    logic [4:0] rd_idx;
    logic [1:0] result, dbg_state;

    always #5 clk = ~clk;

    vad_frame_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_en      (read_en),
        .empty        (empty),
        .wr_en        (wr_en),
        .wr_slot      (wr_slot),
        .rd_en        (rd_en),
        .rd_slot      (rd_slot),
        .rd_idx       (rd_idx),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_result  (core_result),
        .result       (result),
        .result_valid (result_valid),
        .frames_held  (frames_held),
        .dbg_state_o  (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: counts accepted frames and stream progress with plain integers.
    int         m_total;
    int         m_j;
    bit         m_wait;
    bit         m_valid = 1'b0;
    logic [1:0] m_res;
    bit         m_rv;
    int         m_stream_total;

    function automatic logic [20:0] model_exp(input logic re);
        bit e;
        bit ren;
        int held;
        int slot;
        int idx;
        e    = (m_j < 0) && !m_wait;
        ren  = (m_j >= 0);
        held = (m_total > WINDOW) ? WINDOW : m_total;
        slot = ren ? (m_stream_total + m_j / FRAME_LEN) % WINDOW : 0;
        idx  = ren ? m_j % FRAME_LEN : 0;
        return {e, re & e, 3'(m_total % WINDOW), ren, 3'(slot), 5'(idx),
                (m_j == 0), m_res, m_rv, 3'(held)};
    endfunction

    task automatic model_step(input logic re, input logic cd, input logic [1:0] cr, input logic rst);
        if (!rst) begin
            m_total = 0; m_j = -1; m_wait = 0; m_res = 2'b00; m_rv = 0;
            m_stream_total = 0; m_valid = 1'b1;
            return;
        end
        m_rv = 0;
        if (m_j < 0 && !m_wait) begin
            if (re) begin
                m_total++;
                if (m_total >= WINDOW) begin
                    m_j = 0;
                    m_stream_total = m_total;
                end
            end
        end else if (m_j >= 0) begin
            m_j++;
            if (m_j == WINDOW * FRAME_LEN) begin
                m_j = -1;
                m_wait = 1;
            end
        end else if (cd) begin
            m_res  = cr;
            m_rv   = 1;
            m_wait = 0;
        end
    endtask

    logic       cap_empty, cap_wr_en, cap_rd_en, cap_cs, cap_rv;
    logic [2:0] cap_wr_slot, cap_rd_slot, cap_held;
    logic [4:0] cap_rd_idx;
    logic [1:0] cap_result, cap_state;

    // One clock cycle: drive at negedge, sample 1ns later, then advance the model.
    task automatic cycle(input logic re, input logic cd, input logic [1:0] cr, input logic rst);
        logic [20:0] act;
        @(negedge clk);
        read_en = re; core_done = cd; core_result = cr; rst_n = rst;
        #1;
        cap_empty = empty; cap_wr_en = wr_en; cap_wr_slot = wr_slot; cap_rd_en = rd_en;
        cap_rd_slot = rd_slot; cap_rd_idx = rd_idx; cap_cs = core_start; cap_result = result;
        cap_rv = result_valid; cap_held = frames_held; cap_state = dbg_state;
        act = {empty, wr_en, wr_slot, rd_en, rd_en ? rd_slot : 3'd0, rd_en ? rd_idx : 5'd0,
               core_start, result, result_valid, frames_held};
        if (rst && m_valid) check("model_outputs", 32'(act), 32'(model_exp(re)));
        model_step(re, cd, cr, rst);
    endtask

    typedef struct {
        logic       re;
        logic       e_empty;
        logic       e_wr_en;
        logic [2:0] e_slot;
        logic [2:0] e_held;
        logic       e_rd_en;
        logic       e_cs;
    } fill_vec_t;

    fill_vec_t vec[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rd_cnt;
        int  k;
        bit  found;

        vec[0] = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vec[1] = '{1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0};
        vec[2] = '{1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0};
        vec[3] = '{1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0};
        vec[4] = '{1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0};
        vec[5] = '{1'b1, 1'b1, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0};
        vec[6] = '{1'b1, 1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0};
        vec[7] = '{1'b0, 1'b1, 1'b0, 3'd5, 3'd5, 1'b0, 1'b0};
        vec[8] = '{1'b1, 1'b1, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0};
        vec[9] = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd6, 1'b1, 1'b1};

        // Reset for two cycles, then idle.
        cycle(1'b0, 1'b0, 2'b00, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 1'b1);
        check("reset_empty",       32'(cap_empty),   32'd1);
        check("reset_result",      32'(cap_result),  32'd0);
        check("reset_frames_held", 32'(cap_held),    32'd0);
        check("reset_rd_en",       32'(cap_rd_en),   32'd0);
        check("reset_rd_slot",     32'(cap_rd_slot), 32'd0);
        check("reset_rd_idx",      32'(cap_rd_idx),  32'd0);
        check("reset_core_start",  32'(cap_cs),      32'd0);
        check("reset_result_valid",32'(cap_rv),      32'd0);
        check("reset_state",       32'(cap_state),   32'(ST_WAIT_FRAME));

        // Fill six frames with gaps; the stream begins only after the sixth.
        for (int i = 0; i < 10; i++) begin
            cycle(vec[i].re, 1'b0, 2'b00, 1'b1);
            check($sformatf("fill%0d_empty", i), 32'(cap_empty),   32'(vec[i].e_empty));
            check($sformatf("fill%0d_wr_en", i), 32'(cap_wr_en),   32'(vec[i].e_wr_en));
            check($sformatf("fill%0d_slot", i),  32'(cap_wr_slot), 32'(vec[i].e_slot));
            check($sformatf("fill%0d_held", i),  32'(cap_held),    32'(vec[i].e_held));
            check($sformatf("fill%0d_rd_en", i), 32'(cap_rd_en),   32'(vec[i].e_rd_en));
            check($sformatf("fill%0d_cs", i),    32'(cap_cs),      32'(vec[i].e_cs));
        end

        // Rest of the first stream with read_en held high; it must be ignored.
        rd_cnt = 1;
        for (int i = 1; i < WINDOW * FRAME_LEN; i++) begin
            cycle(1'b1, 1'b0, 2'b00, 1'b1);
            if (cap_rd_en) rd_cnt++;
            if (cap_wr_en) check("stream_wr_en", 32'(cap_wr_en), 32'd0);
        end
        check("stream_last_slot", 32'(cap_rd_slot), 32'd5);
        check("stream_last_idx",  32'(cap_rd_idx),  32'd19);

        // Core answers on the tenth WAIT_CORE cycle.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b0, 2'b00, 1'b1);
            if (cap_rd_en) rd_cnt++;
        end
        check("stream_rd_en_cycles", 32'(rd_cnt), 32'd120);
        check("wait_core_empty",     32'(cap_empty), 32'd0);
        check("wait_core_wr_slot",   32'(cap_wr_slot), 32'd0);
        cycle(1'b0, 1'b1, 2'b01, 1'b1);
        cycle(1'b0, 1'b0, 2'b00, 1'b1);
        check("decision_result", 32'(cap_result), 32'd1);
        check("decision_valid",  32'(cap_rv),     32'd1);
        check("decision_empty",  32'(cap_empty),  32'd1);
        cycle(1'b0, 1'b1, 2'b11, 1'b1);
        check("decision_pulse_once", 32'(cap_rv), 32'd0);
        cycle(1'b0, 1'b0, 2'b00, 1'b1);
        check("stray_done_result", 32'(cap_result), 32'd1);

        // Seventh frame overwrites slot 0 and streams slots 1..5,0.
        cycle(1'b1, 1'b0, 2'b00, 1'b1);
        check("slide_wr_en",   32'(cap_wr_en),   32'd1);
        check("slide_wr_slot", 32'(cap_wr_slot), 32'd0);
        cycle(1'b0, 1'b0, 2'b00, 1'b1);
        check("slide_first_slot", 32'(cap_rd_slot), 32'd1);
        check("slide_first_idx",  32'(cap_rd_idx),  32'd0);
        check("slide_core_start", 32'(cap_cs),      32'd1);
        for (int i = 1; i < WINDOW * FRAME_LEN; i++) cycle(1'b0, 1'b0, 2'b00, 1'b1);
        check("slide_last_rd_en", 32'(cap_rd_en),   32'd1);
        check("slide_last_slot",  32'(cap_rd_slot), 32'd0);
        check("slide_last_idx",   32'(cap_rd_idx),  32'd19);
        cycle(1'b0, 1'b0, 2'b00, 1'b1);
        check("slide_after_rd_en", 32'(cap_rd_en), 32'd0);
        cycle(1'b0, 1'b0, 2'b00, 1'b1);
        cycle(1'b0, 1'b1, 2'b10, 1'b1);
        cycle(1'b0, 1'b0, 2'b00, 1'b1);
        check("slide_result", 32'(cap_result), 32'd2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 999) != 0));
        end

        // Reset in the middle of a stream at rd_idx 7, with a core_done in flight.
        cycle(1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < WINDOW; i++) cycle(1'b1, 1'b0, 2'b00, 1'b1);
        found = 1'b0;
        k = 0;
        while (!found && k < 200) begin
            cycle(1'b0, 1'b0, 2'b00, 1'b1);
            if (cap_rd_en && cap_rd_idx == 5'd7) found = 1'b1;
            k++;
        end
        check("midstream_reached_idx7", 32'(found), 32'd1);
        cycle(1'b0, 1'b1, 2'b11, 1'b0);
        cycle(1'b0, 1'b1, 2'b11, 1'b1);
        check("midreset_state", 32'(cap_state), 32'(ST_WAIT_FRAME));
        check("midreset_held",  32'(cap_held),  32'd0);
        check("midreset_rd_en", 32'(cap_rd_en), 32'd0);
        check("midreset_empty", 32'(cap_empty), 32'd1);
        cycle(1'b0, 1'b0, 2'b00, 1'b1);
        check("midreset_result",       32'(cap_result), 32'd0);
        check("midreset_result_valid", 32'(cap_rv),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
